// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer
//   Elastic buffer between a bursty host write port and the DAC serialiser.
//   Incoming words go into a synchronous FIFO. Once the FIFO holds PRIME
//   words, playback starts and exactly one word is released per DIV-cycle
//   sample period. A free-running divider sets that period.
//
// Ports
//   clk_i        system clock
//   reset_i      synchronous, active-high reset
//   data_i       sample word from the host
//   data_rdy_i   one-cycle write strobe for data_i
//   flags_clr_i  one-cycle strobe that clears the sticky flags
//   data_o       registered sample to the serialiser
//   data_rdy_o   one-cycle strobe: data_o updated
//   fill_o       FIFO occupancy, 0..2**DEPTH_LOG2
//   playing_o    high while releasing samples
//   underrun_o   sticky: a sample tick found the FIFO empty while playing
//   overflow_o   sticky: a write was dropped because the FIFO was full
module dac_sample_pacer #(
    parameter int DATA_W     = 14,
    parameter int DEPTH_LOG2 = 9,
    parameter int DIV        = 816,
    parameter int PRIME      = 256
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  data_rdy_i,
    input  logic                  flags_clr_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  data_rdy_o,
    output logic [DEPTH_LOG2:0]   fill_o,
    output logic                  playing_o,
    output logic                  underrun_o,
    output logic                  overflow_o
);

    localparam int                 DEPTH   = 1 << DEPTH_LOG2;
    localparam int                 CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [DEPTH_LOG2:0] PRIME_L = (DEPTH_LOG2 + 1)'(PRIME);

    typedef enum logic {PRIMING, PLAYING} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       div_q, div_d;
    logic [DEPTH_LOG2:0]    wptr_q, wptr_d, rptr_q, rptr_d, fill_d;
    logic                   rdy_q, rdy_d;
    logic                   und_q, und_d, ovf_q, ovf_d;
    logic [DATA_W-1:0]      data_q;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic tick, empty, full, pop, push, und_ev, ovf_ev;

    always_comb begin
        tick  = (div_q == CNT_MAX);
        empty = (wptr_q == rptr_q);
        // Same slot index but opposite wrap bit means the write pointer has
        // lapped the read pointer once.
        full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

        pop    = (state_q == PLAYING) && tick && !empty;
        und_ev = (state_q == PLAYING) && tick && empty;
        // A full FIFO still accepts a write when a pop frees a slot in the
        // same cycle.
        push   = data_rdy_i && (!full || pop);
        ovf_ev = data_rdy_i && !push;

        div_d  = tick ? '0 : div_q + CNT_W'(1);
        wptr_d = wptr_q + (DEPTH_LOG2 + 1)'(push);
        rptr_d = rptr_q + (DEPTH_LOG2 + 1)'(pop);
        fill_d = wptr_d - rptr_d;
        rdy_d  = pop;

        // A set event in the same cycle as a clear wins.
        und_d  = (und_q && !flags_clr_i) || und_ev;
        ovf_d  = (ovf_q && !flags_clr_i) || ovf_ev;

        state_d = state_q;
        case (state_q)
            PRIMING: if (fill_d >= PRIME_L) state_d = PLAYING;
            PLAYING: if (und_ev)            state_d = PRIMING;
            default:                        state_d = PRIMING;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= PRIMING;
            div_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdy_q   <= 1'b0;
            und_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdy_q   <= rdy_d;
            und_q   <= und_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage has no reset so it maps onto block RAM. On full with a
    // simultaneous push and pop, both ports address the same slot; the read
    // returns the old head, which is the word being popped.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= data_i;
    end

    // Registered read port: the popped word appears on data_o one cycle
    // after the tick, and it holds between pops.
    always_ff @(posedge clk_i) begin
        if (reset_i)  data_q <= '0;
        else if (pop) data_q <= mem_q[rptr_q[DEPTH_LOG2-1:0]];
    end

    assign data_o     = data_q;
    assign data_rdy_o = rdy_q;
    assign fill_o     = wptr_q - rptr_q;
    assign playing_o  = (state_q == PLAYING);
    assign underrun_o = und_q;
    assign overflow_o = ovf_q;

endmodule
